// File: rtl/sb3320_path_sequencer_if.sv
// Planner / line-follower handshake bundle for the path sequencer.
// master: path source and junction events; slave: the sequencer.
interface sb3320_path_sequencer_if #(
  parameter int NODE_W   = 5,
  parameter int PATH_LEN = 10
);
  logic                         path_valid;
  logic [NODE_W*PATH_LEN-1:0]   path_in;
  logic                         node_reached;
  logic [NODE_W-1:0]            prev_node;
  logic [NODE_W-1:0]            curr_node;
  logic [NODE_W-1:0]            next_node;
  logic                         dir_start;
  logic [3:0]                   remaining;
  logic                         busy;
  logic                         goal_reached;
  logic                         path_error;

  modport master (
    output path_valid,
    output path_in,
    output node_reached,
    input  prev_node,
    input  curr_node,
    input  next_node,
    input  dir_start,
    input  remaining,
    input  busy,
    input  goal_reached,
    input  path_error
  );

  modport slave (
    input  path_valid,
    input  path_in,
    input  node_reached,
    output prev_node,
    output curr_node,
    output next_node,
    output dir_start,
    output remaining,
    output busy,
    output goal_reached,
    output path_error
  );
endinterface

// File: rtl/sb3320_path_sequencer.sv
// Walks a latched planner path one junction at a time and emits
// {prev,curr,next} triples with a dir_start pulse per triple.
// Ports: clk_50, reset (async, active-high), bus (slave):
//   in : path_valid, path_in, node_reached
//   out: prev/curr/next_node, dir_start, remaining, busy,
//        goal_reached, path_error
module sb3320_path_sequencer #(
  parameter int NODE_W   = 5,
  parameter int PATH_LEN = 10,
  parameter int PAD_NODE = 27
) (
  input  logic                   clk_50,
  input  logic                   reset,
  sb3320_path_sequencer_if.slave bus
);

  localparam int IDX_W = 4;
  localparam logic [NODE_W-1:0] PAD  = NODE_W'(PAD_NODE);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(PATH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nx;
  logic [PATH_LEN-1:0][NODE_W-1:0]  r_slot;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W-1:0]                 w_idx_nx;
  logic [NODE_W-1:0]                r_prev;
  logic [NODE_W-1:0]                r_curr;
  logic [NODE_W-1:0]                r_next;
  logic [NODE_W-1:0]                w_prev_nx;
  logic [NODE_W-1:0]                w_curr_nx;
  logic [NODE_W-1:0]                w_next_nx;
  logic [IDX_W-1:0]                 r_rem;
  logic [IDX_W-1:0]                 w_rem_nx;
  logic                             r_dir;
  logic                             w_dir_nx;
  logic                             r_busy;
  logic                             r_goal;
  logic                             r_err;
  logic                             w_load;

  logic [IDX_W-1:0]                 w_im1;
  logic [IDX_W-1:0]                 w_im2;
  logic [NODE_W-1:0]                w_slot_i;
  logic [NODE_W-1:0]                w_slot_m1;
  logic [NODE_W-1:0]                w_slot_m2;

  assign w_im1 = r_idx - 1'b1;
  assign w_im2 = r_idx - 2'd2;

  // Slot reads at idx, idx-1, idx-2. Underflowed indices
  // match no slot and read as padding.
  always_comb begin
    w_slot_i  = PAD;
    w_slot_m1 = PAD;
    w_slot_m2 = PAD;
    for (int i = 0; i < PATH_LEN; i++) begin
      if (IDX_W'(i) == r_idx) w_slot_i  = r_slot[i];
      if (IDX_W'(i) == w_im1) w_slot_m1 = r_slot[i];
      if (IDX_W'(i) == w_im2) w_slot_m2 = r_slot[i];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_prev_nx  = r_prev;
    w_curr_nx  = r_curr;
    w_next_nx  = r_next;
    w_rem_nx   = r_rem;
    w_dir_nx   = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.path_valid) begin
          w_load     = 1'b1;
          w_idx_nx   = LAST;
          w_state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_slot_i == PAD && r_idx != '0) begin
          w_idx_nx = w_im1;
        end else if (w_slot_i == PAD) begin
          w_state_nx = S_ERROR;
        end else begin
          w_prev_nx  = PAD;
          w_curr_nx  = w_slot_i;
          w_next_nx  = (r_idx != '0) ? w_slot_m1 : PAD;
          w_rem_nx   = r_idx;
          w_dir_nx   = 1'b1;
          w_state_nx = (r_idx != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (bus.node_reached) begin
          // A pad where the bot is about to stand, or one hop
          // beyond it, means the path is broken mid-way.
          if (w_slot_m1 == PAD) begin
            w_state_nx = S_ERROR;
          end else if (w_im1 == '0) begin
            w_idx_nx   = '0;
            w_prev_nx  = r_curr;
            w_curr_nx  = r_next;
            w_next_nx  = PAD;
            w_rem_nx   = '0;
            w_dir_nx   = 1'b1;
            w_state_nx = S_DONE;
          end else if (w_slot_m2 == PAD) begin
            w_state_nx = S_ERROR;
          end else begin
            w_idx_nx   = w_im1;
            w_prev_nx  = r_curr;
            w_curr_nx  = r_next;
            w_next_nx  = w_slot_m2;
            w_rem_nx   = w_im1;
            w_dir_nx   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_slot  <= {PATH_LEN{PAD}};
      r_idx   <= '0;
      r_prev  <= PAD;
      r_curr  <= PAD;
      r_next  <= PAD;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_goal  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) r_slot <= bus.path_in;
      r_idx   <= w_idx_nx;
      r_prev  <= w_prev_nx;
      r_curr  <= w_curr_nx;
      r_next  <= w_next_nx;
      r_rem   <= w_rem_nx;
      r_dir   <= w_dir_nx;
      r_busy  <= (w_state_nx == S_SCAN) ||
                 (w_state_nx == S_RUN);
      r_goal  <= (w_state_nx == S_DONE);
      r_err   <= (w_state_nx == S_ERROR);
    end
  end

  assign bus.prev_node    = r_prev;
  assign bus.curr_node    = r_curr;
  assign bus.next_node    = r_next;
  assign bus.remaining    = r_rem;
  assign bus.dir_start    = r_dir;
  assign bus.busy         = r_busy;
  assign bus.goal_reached = r_goal;
  assign bus.path_error   = r_err;

endmodule

// File: tb/tb_sb3320_path_sequencer.sv
// Randomized bench for sb3320_path_sequencer against a
// path-level reference model.
module tb_sb3320_path_sequencer;

  localparam int PAD = 27;
  localparam int M_IDLE = 0;
  localparam int M_SCAN = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;

  sb3320_path_sequencer_if #(.NODE_W(5), .PATH_LEN(10)) bus ();

  sb3320_path_sequencer #(
    .NODE_W  (5),
    .PATH_LEN(10),
    .PAD_NODE(PAD)
  ) dut (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_50 = ~clk_50;

  int n_vec = 0;
  int n_err = 0;

  int e_prev, e_curr, e_next, e_rem;
  int e_dir, e_goal, e_err;
  int mode;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".prev"}, 32'(bus.prev_node), e_prev);
    chk({tag, ".curr"}, 32'(bus.curr_node), e_curr);
    chk({tag, ".next"}, 32'(bus.next_node), e_next);
    chk({tag, ".rem"},  32'(bus.remaining), e_rem);
    chk({tag, ".dir"},  32'(bus.dir_start), e_dir);
    chk({tag, ".busy"}, 32'(bus.busy),
        (mode == M_SCAN || mode == M_RUN) ? 1 : 0);
    chk({tag, ".goal"}, 32'(bus.goal_reached), e_goal);
    chk({tag, ".err"},  32'(bus.path_error), e_err);
  endtask

  task automatic model_reset();
    e_prev = PAD; e_curr = PAD; e_next = PAD; e_rem = 0;
    e_dir = 0; e_goal = 0; e_err = 0;
    mode = M_IDLE;
  endtask

  task automatic cyc();
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic quiet();
    bus.path_valid   = 1'b0;
    bus.node_reached = 1'b0;
  endtask

  // Triple seen when standing at slot pos of path p with
  // start slot s: neighbours along the path, PAD off either end.
  task automatic set_triple(input int p[10], input int s,
                            input int pos);
    e_prev = (pos == s) ? PAD : p[pos+1];
    e_curr = p[pos];
    e_next = (pos > 0) ? p[pos-1] : PAD;
    e_rem  = pos;
  endtask

  function automatic logic [49:0] rnd_path();
    logic [49:0] v;
    int kind, s, j, n;
    v = '0;
    kind = $urandom_range(0, 9);
    s = $urandom_range(0, 9);
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 31);
      if (n == PAD) n = 0;
      if (kind == 0 || i > s) n = PAD;
      v[5*i +: 5] = 5'(n);
    end
    if (kind <= 2 && kind != 0 && s > 0) begin
      j = $urandom_range(0, s - 1);
      v[5*j +: 5] = 5'(PAD);
    end
    return v;
  endfunction

  task automatic run_path(input logic [49:0] pin,
                          input bit noise);
    int p[10];
    int pads, s, pos, scan, gap;
    for (int i = 0; i < 10; i++) p[i] = int'(pin[5*i +: 5]);
    pads = 0;
    for (int i = 9; i >= 0; i--) begin
      if (p[i] != PAD) break;
      pads++;
    end
    s = 9 - pads;

    bus.path_in      = pin;
    bus.path_valid   = 1'b1;
    bus.node_reached = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc();
    quiet();
    e_goal = 0; e_err = 0; e_dir = 0;
    mode = M_SCAN;
    chk_all("load");

    // Leading pads cost one cycle each; an all-pad path
    // stops at slot 0.
    scan = (pads > 9) ? 9 : pads;
    repeat (scan) begin
      if (noise) begin
        bus.path_valid   = 1'($urandom_range(0, 1));
        bus.path_in      = rnd_path();
        bus.node_reached = 1'($urandom_range(0, 1));
      end
      cyc();
      quiet();
      chk_all("scan");
    end
    if (noise) begin
      bus.path_valid   = 1'($urandom_range(0, 1));
      bus.path_in      = rnd_path();
      bus.node_reached = 1'($urandom_range(0, 1));
    end
    cyc();
    quiet();

    if (s < 0) begin
      mode = M_ERR; e_err = 1;
    end else begin
      pos = s;
      set_triple(p, s, pos);
      e_dir = 1;
      mode  = (s > 0) ? M_RUN : M_DONE;
      e_goal = (s == 0) ? 1 : 0;
    end
    chk_all("start");
    e_dir = 0;

    while (mode == M_RUN) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        if (noise) begin
          bus.path_valid = 1'($urandom_range(0, 1));
          bus.path_in    = rnd_path();
        end
        cyc();
        quiet();
        chk_all("hold");
      end
      bus.node_reached = 1'b1;
      cyc();
      quiet();
      // Moving onto a pad, or with a pad one hop beyond the
      // new position, is a broken path; the triple freezes.
      if (p[pos-1] == PAD ||
          (pos - 1 > 0 && p[pos-2] == PAD)) begin
        mode = M_ERR; e_err = 1;
      end else begin
        pos--;
        set_triple(p, s, pos);
        e_dir = 1;
        if (pos == 0) begin
          mode = M_DONE; e_goal = 1;
        end
      end
      chk_all("reach");
      e_dir = 0;
    end

    repeat (2) begin
      bus.node_reached = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      quiet();
      chk_all("rest");
    end
  endtask

  localparam logic [49:0] T1 =
    {{7{5'd27}}, 5'd0, 5'd3, 5'd8};
  localparam logic [49:0] T2 = {10{5'd27}};
  localparam logic [49:0] T3 =
    {{6{5'd27}}, 5'd0, 5'd27, 5'd5, 5'd8};
  localparam logic [49:0] T4 = {{9{5'd27}}, 5'd14};

  initial begin
    bus.path_in = '0;
    quiet();
    model_reset();
    @(negedge clk_50);
    chk_all("rst");
    reset = 1'b0;
    cyc();
    chk_all("idle");

    run_path(T1, 1'b0);
    run_path(T2, 1'b0);
    run_path(T3, 1'b0);
    run_path(T4, 1'b0);
    run_path(T1, 1'b1);

    // Asynchronous reset in the middle of a walk.
    bus.path_in    = T1;
    bus.path_valid = 1'b1;
    cyc();
    quiet();
    repeat (9) cyc();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk_50);
    chk_all("rst_hold");
    reset = 1'b0;
    cyc();
    run_path(T1, 1'b0);

    for (int n = 0; n < 150; n++)
      run_path(rnd_path(), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
